// File: rtl/ib_mul_iter.sv
// ib_mul_iter: iterative WIDTH x WIDTH shift-add multiplier.
// Retires BPC multiplier bits per cycle (WIDTH/BPC cycles per product),
// with valid/ready on both the operand and the product side.
// Signed mode multiplies magnitudes and negates the result at the end.
//
//   state | meaning
//   IDLE  | o_ready=1, waiting for operands
//   BUSY  | accumulating partial products, counter running down
//   DONE  | o_valid=1, product held on o_c until i_ready
module ib_mul_iter #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic                 i_signed,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [2*WIDTH-1:0]   o_c
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] mcand_sh;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [CW-1:0]      cnt;
  logic               neg;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1),
  // which still fits in WIDTH unsigned bits.
  always_comb begin
    mag_a = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    mag_b = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
  end

  // Partial product of the shifted multiplicand and the low BPC multiplier bits.
  always_comb begin
    partial = '0;
    for (int i = 0; i < BPC; i++) begin
      if (mplier[i]) begin
        partial = partial + (mcand_sh << i);
      end
    end
    acc_next = acc + partial;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state    <= IDLE;
      mcand_sh <= '0;
      acc      <= '0;
      mplier   <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      o_c      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            mcand_sh <= {{WIDTH{1'b0}}, mag_a};
            mplier   <= mag_b;
            acc      <= '0;
            cnt      <= CW'(N);
            neg      <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc      <= acc_next;
          mcand_sh <= mcand_sh << BPC;
          mplier   <= mplier >> BPC;
          cnt      <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            o_c   <= neg ? -acc_next : acc_next;
            state <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from state.
  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);

endmodule

// File: tb/tb_ib_mul_iter.sv
// Testbench for ib_mul_iter: three instances (8x8/BPC1, 16x16/BPC4,
// 8x8/BPC2) checked against an integer-arithmetic reference model.
module tb_ib_mul_iter;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  // instance 0: WIDTH=8 BPC=1
  logic va0 = 0, s0 = 0, rdy0 = 0, ordy0, ov0;
  logic [7:0] a0 = 0, b0 = 0;
  logic [15:0] c0;
  // instance 1: WIDTH=16 BPC=4
  logic va1 = 0, s1 = 0, rdy1 = 0, ordy1, ov1;
  logic [15:0] a1 = 0, b1 = 0;
  logic [31:0] c1;
  // instance 2: WIDTH=8 BPC=2
  logic va2 = 0, s2 = 0, rdy2 = 0, ordy2, ov2;
  logic [7:0] a2 = 0, b2 = 0;
  logic [15:0] c2;

  ib_mul_iter #(.WIDTH(8), .BPC(1)) dut0 (
    .i_clk(clk), .i_nrst(nrst), .i_valid(va0), .o_ready(ordy0), .i_a(a0), .i_b(b0),
    .i_signed(s0), .o_valid(ov0), .i_ready(rdy0), .o_c(c0));
  ib_mul_iter #(.WIDTH(16), .BPC(4)) dut1 (
    .i_clk(clk), .i_nrst(nrst), .i_valid(va1), .o_ready(ordy1), .i_a(a1), .i_b(b1),
    .i_signed(s1), .o_valid(ov1), .i_ready(rdy1), .o_c(c1));
  ib_mul_iter #(.WIDTH(8), .BPC(2)) dut2 (
    .i_clk(clk), .i_nrst(nrst), .i_valid(va2), .o_ready(ordy2), .i_a(a2), .i_b(b2),
    .i_signed(s2), .o_valid(ov2), .i_ready(rdy2), .o_c(c2));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int width_of(input int sel);
    return (sel == 1) ? 16 : 8;
  endfunction

  function automatic int lat_of(input int sel);
    return (sel == 0) ? 8 : 4;
  endfunction

  // Reference: plain integer product of the operands read as signed or unsigned.
  function automatic logic [31:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input bit s);
    longint x, y, p;
    x = longint'(a) & ((longint'(1) << w) - 1);
    y = longint'(b) & ((longint'(1) << w) - 1);
    if (s && x[w-1]) x = x - (longint'(1) << w);
    if (s && y[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic drive(input int sel, input bit v, input logic [15:0] a, input logic [15:0] b,
                       input bit s);
    case (sel)
      0: begin va0 = v; a0 = a[7:0]; b0 = b[7:0]; s0 = s; end
      1: begin va1 = v; a1 = a;      b1 = b;      s1 = s; end
      default: begin va2 = v; a2 = a[7:0]; b2 = b[7:0]; s2 = s; end
    endcase
  endtask

  task automatic set_rdy(input int sel, input bit r);
    case (sel)
      0: rdy0 = r;
      1: rdy1 = r;
      default: rdy2 = r;
    endcase
  endtask

  function automatic bit get_or(input int sel);
    return (sel == 0) ? ordy0 : (sel == 1) ? ordy1 : ordy2;
  endfunction

  function automatic bit get_ov(input int sel);
    return (sel == 0) ? ov0 : (sel == 1) ? ov1 : ov2;
  endfunction

  function automatic logic [31:0] get_c(input int sel);
    return (sel == 0) ? {16'h0, c0} : (sel == 1) ? c1 : {16'h0, c2};
  endfunction

  function automatic logic [15:0] rnd16();
    return 16'($urandom);
  endfunction

  // One transaction: accept, check latency, optional stall with an ignored
  // i_valid pulse, then handoff. Called and returns at a negedge.
  task automatic run(input int sel, input logic [15:0] a, input logic [15:0] b, input bit s,
                     input int stall, input string nm, output logic [31:0] c);
    int guard = 0;
    int lat = 0;
    while (!get_or(sel) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk({nm, " ready"}, 32'(get_or(sel)), 32'd1);
    drive(sel, 1'b1, a, b, s);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, rnd16(), rnd16(), 1'($urandom));
    while (!get_ov(sel) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(lat_of(sel)));
    chk({nm, " ready low"}, 32'(get_or(sel)), 32'd0);
    c = get_c(sel);
    for (int k = 0; k < stall; k++) begin
      drive(sel, k == 1, rnd16(), rnd16(), 1'($urandom));
      @(negedge clk);
      chk({nm, " stall o_c"}, get_c(sel), c);
      chk({nm, " stall valid"}, 32'(get_ov(sel)), 32'd1);
      chk({nm, " stall ready"}, 32'(get_or(sel)), 32'd0);
    end
    drive(sel, 1'b0, 16'h0, 16'h0, 1'b0);
    set_rdy(sel, 1'b1);
    @(negedge clk);
    set_rdy(sel, 1'b0);
    chk({nm, " post valid"}, 32'(get_ov(sel)), 32'd0);
    chk({nm, " post ready"}, 32'(get_or(sel)), 32'd1);
  endtask

  // Continuous traffic: i_valid and i_ready high; checks data order and N+2 spacing.
  task automatic b2b(input int sel, input int nprod);
    logic [31:0] q[$];
    logic [15:0] a, b;
    bit s, pend;
    int got, cyc, last;
    got = 0; cyc = 0; last = -1; pend = 0;
    a = rnd16(); b = rnd16(); s = 1'($urandom);
    drive(sel, 1'b1, a, b, s);
    set_rdy(sel, 1'b1);
    while (got < nprod && cyc < 2000) begin
      if (get_or(sel)) begin
        q.push_back(model(width_of(sel), a, b, s));
        pend = 1;
      end
      @(negedge clk);
      cyc++;
      if (pend) begin
        a = rnd16(); b = rnd16(); s = 1'($urandom);
        drive(sel, 1'b1, a, b, s);
        pend = 0;
      end
      if (get_ov(sel)) begin
        chk("b2b both high", 32'(get_or(sel)), 32'd0);
        if (q.size() == 0) chk("b2b extra product", get_c(sel), 32'hx);
        else chk("b2b data", get_c(sel), q.pop_front());
        if (last >= 0) chk("b2b interval", 32'(cyc - last), 32'(lat_of(sel) + 2));
        last = cyc;
        got++;
      end
    end
    chk("b2b count", 32'(got), 32'(nprod));
    drive(sel, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (get_ov(sel) && q.size() > 0) chk("b2b drain data", get_c(sel), q.pop_front());
    end
    chk("b2b none dropped", 32'(q.size()), 32'd0);
    set_rdy(sel, 1'b0);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    bit          s;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] c;
    logic [15:0] ra, rb;
    bit rs;

    tbl[0] = '{8'd13, 8'd11, 1'b0, 16'h008F};
    tbl[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[2] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[3] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    tbl[4] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    tbl[5] = '{8'h00, 8'hFF, 1'b0, 16'h0000};
    tbl[6] = '{8'h80, 8'h01, 1'b1, 16'hFF80};
    tbl[7] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    tbl[8] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    tbl[9] = '{8'h80, 8'h80, 1'b0, 16'h4000};

    repeat (3) @(negedge clk);
    chk("reset ready0", 32'(ordy0), 32'd1);
    chk("reset valid0", 32'(ov0), 32'd0);
    chk("reset c0", {16'h0, c0}, 32'd0);
    chk("reset c1", c1, 32'd0);
    chk("reset ready2", 32'(ordy2), 32'd1);
    nrst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      for (int sel = 0; sel < 3; sel += 2) begin
        run(sel, {8'h0, tbl[i].a}, {8'h0, tbl[i].b}, tbl[i].s, 0, $sformatf("tbl%0d.%0d", i, sel), c);
        chk($sformatf("tbl%0d.%0d product", i, sel), c, {16'h0, tbl[i].exp});
      end
    end

    // Backpressure: 5 stalled cycles with an i_valid pulse that must be ignored.
    run(0, 16'd200, 16'd3, 1'b0, 5, "stall", c);
    chk("stall product", c, 32'd600);
    run(0, 16'd5, 16'd9, 1'b0, 0, "after stall", c);
    chk("after stall product", c, 32'd45);

    // Reset three cycles after accept.
    drive(0, 1'b1, 16'd100, 16'd100, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("midrst valid", 32'(ov0), 32'd0);
    chk("midrst ready", 32'(ordy0), 32'd1);
    chk("midrst c", {16'h0, c0}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    run(0, 16'd6, 16'd7, 1'b0, 0, "after rst", c);
    chk("after rst product", c, 32'h2A);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("after rst idle", 32'(ov0), 32'd0);
    end

    // Wide instance corner cases.
    run(1, 16'hFFFF, 16'hFFFF, 1'b0, 0, "w16 max", c);
    chk("w16 max product", c, 32'hFFFE0001);
    run(1, 16'h8000, 16'h8000, 1'b1, 2, "w16 minneg", c);
    chk("w16 minneg product", c, 32'h40000000);
    run(1, 16'h8000, 16'h7FFF, 1'b1, 0, "w16 mixed", c);
    chk("w16 mixed product", c, 32'hC0008000);

    // Randomized transactions on all instances.
    for (int sel = 0; sel < 3; sel++) begin
      for (int i = 0; i < 150; i++) begin
        ra = rnd16(); rb = rnd16(); rs = 1'($urandom);
        run(sel, ra, rb, rs, int'($urandom_range(0, 2)), $sformatf("rand%0d.%0d", sel, i), c);
        chk($sformatf("rand%0d.%0d product a=%h b=%h s=%0d", sel, i, ra, rb, rs), c,
            model(width_of(sel), ra, rb, rs));
      end
    end

    for (int sel = 0; sel < 3; sel++) b2b(sel, 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
